// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer and the control unit:
// RV32 opcode fields, jump-select encodings, sequencer states and the NOP word.
package fetch_sequencer_pkg;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    localparam logic [1:0] JAL_SEQ  = 2'b00;
    localparam logic [1:0] JAL_RSVD = 2'b01;
    localparam logic [1:0] JAL_JAL  = 2'b10;
    localparam logic [1:0] JAL_JALR = 2'b11;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    function automatic logic [4:0] opcode_of(input logic [31:0] word);
        return word[6:2];
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/valid handshake between the fetch sequencer and imem.
interface fetch_sequencer_if;
    logic        req;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input rvalid, input rdata);
    modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/fetch_sequencer_next_pc.sv
// Next-PC target selection for the instruction in EXEC, plus the flag that the
// chosen target is not word aligned.
module fetch_sequencer_next_pc
    import fetch_sequencer_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic [1:0]  jal,
    input  logic        branch,
    input  logic        branch_taken,
    output logic [31:0] next_pc,
    output logic        target_misaligned
);

    always_comb begin
        next_pc = pc + 32'd4;
        if (jal == JAL_JALR) begin
            next_pc = (rs1_data + imm) & ~32'h1;
        end else if (jal == JAL_JAL) begin
            next_pc = pc + imm;
        end else if (branch && branch_taken) begin
            next_pc = pc + imm;
        end
    end

    // Bit 0 is always even for legal encodings; only bit 1 can break word alignment.
    assign target_misaligned = next_pc[1];

endmodule

// File: rtl/fetch_sequencer.sv
// PC / instruction-fetch sequencer: fetches over the imem handshake, holds the
// instruction for one EXEC cycle, picks the next PC and halts on stop or bad target.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    fetch_sequencer_if.master  imem,
    output logic [31:0]        instr,
    output logic [4:0]         opcode,
    output logic               instr_valid,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    input  logic               branch,
    input  logic               branch_taken,
    input  logic [1:0]         jal,
    input  logic               stopflag,
    input  logic [31:0]        imm,
    input  logic [31:0]        rs1_data,
    output logic               halted,
    output logic               misaligned,
    output logic [CNT_W-1:0]   retire_count
);

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        instr_q, instr_d;
    logic               misaligned_q, misaligned_d;
    logic [CNT_W-1:0]   retire_q, retire_d;

    logic [31:0]        next_pc;
    logic               target_misaligned;

    fetch_sequencer_next_pc u_next_pc (
        .pc                (pc_q),
        .imm               (imm),
        .rs1_data          (rs1_data),
        .jal               (jal),
        .branch            (branch),
        .branch_taken      (branch_taken),
        .next_pc           (next_pc),
        .target_misaligned (target_misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            misaligned_q <= 1'b0;
            retire_q     <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            misaligned_q <= misaligned_d;
            retire_q     <= retire_d;
        end
    end

    // A stop retires its own instruction; a bad target does not retire the jump.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        misaligned_d = misaligned_q;
        retire_d     = retire_q;
        case (state_q)
            ST_FETCH: begin
                if (imem.rvalid) begin
                    instr_d = imem.rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (stopflag) begin
                    retire_d = retire_q + CNT_W'(1);
                    state_d  = ST_HALT;
                end else if (target_misaligned) begin
                    misaligned_d = 1'b1;
                    state_d      = ST_HALT;
                end else begin
                    pc_d     = next_pc;
                    retire_d = retire_q + CNT_W'(1);
                    state_d  = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    assign imem.req     = (state_q == ST_FETCH);
    assign imem.addr    = pc_q;
    assign instr        = instr_q;
    assign opcode       = opcode_of(instr_q);
    assign instr_valid  = (state_q == ST_EXEC);
    assign pc           = pc_q;
    assign pc_plus4     = pc_q + 32'd4;
    assign halted       = (state_q == ST_HALT);
    assign misaligned   = misaligned_q;
    assign retire_count = retire_q;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter and instruction-fetch sequencer for the RISC-V core: holds the PC, fetches each instruction from instruction memory over a request/valid handshake, and presents the instruction and its 5-bit opcode field to the control unit. It consumes the control unit's branch, jump and stop outputs plus the branch comparator result to choose the next PC. It halts the core on a stop instruction or a misaligned target, and counts retired instructions.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- CNT_W, 32, width of retire counter
- clk  in  1  system clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request, held until accepted
- imem_addr  out  32  fetch address (= pc)
- imem_rvalid  in  1  instruction data valid
- imem_rdata  in  32  instruction word
- instr  out  32  latched instruction
- opcode  out  5  instr[6:2], to control unit
- instr_valid  out  1  commit strobe; downstream register and memory writes are qualified by it
- pc  out  32  address of current instruction
- pc_plus4  out  32  pc + 4 (JAL/JALR link value)
- branch  in  1  conditional-branch instruction
- branch_taken  in  1  comparator result for current instruction
- jal  in  2  2'b00 sequential, 2'b10 JAL, 2'b11 JALR, 2'b01 reserved (treated as sequential)
- stopflag  in  1  stop instruction (SYSTEM/custom)
- imm  in  32  sign-extended immediate
- rs1_data  in  32  register-file rs1 read value
- halted  out  1  core stopped
- misaligned  out  1  halt caused by misaligned target
- retire_count  out  CNT_W  instructions retired

## Operation
- States: FETCH, EXEC, HALT. Reset state FETCH.
- FETCH: imem_req=1, imem_addr=pc. On imem_rvalid: instr<=imem_rdata, go to EXEC. imem_rvalid is ignored in EXEC and HALT.
- EXEC: instr_valid=1 for exactly one cycle. The control unit and the branch/jump inputs are combinationally valid this cycle. next_pc is selected in this priority:
  - jal==2'b11: (rs1_data + imm) & ~32'h1
  - jal==2'b10: pc + imm
  - branch && branch_taken: pc + imm
  - otherwise: pc + 4
- End of EXEC:
  - stopflag=1: retire_count++, pc unchanged, go to HALT, halted=1. stopflag takes priority over the target check.
  - else next_pc[1]=1: misaligned=1, halted=1, pc unchanged, retire_count unchanged, go to HALT.
  - else: pc<=next_pc, retire_count++, go to FETCH.
- HALT: absorbing state. imem_req=0, instr_valid=0. Only rst exits.
- All adds are 32-bit modulo, so wrap-around is silent (32'hFFFF_FFFC + 4 = 0). retire_count wraps at 2^CNT_W.

## Timing
- Reset values: pc=RESET_PC, instr=32'h0000_0013 (NOP), opcode=5'b00100, instr_valid=0, halted=0, misaligned=0, retire_count=0, state FETCH. imem_req is asserted combinationally in FETCH, so it is 1 during reset.
- Assertion of rst forces reset values immediately, including mid-FETCH or mid-EXEC. Instruction memory shares rst, so no stale response arrives after reset.
- Minimum of 2 cycles per instruction when imem_rvalid arrives in the first FETCH cycle. Each FETCH wait cycle adds 1.
- imem_rvalid is legal in the same cycle imem_req rises. The response is taken in that cycle.
- pc_plus4, opcode, imem_addr and instr_valid are combinational from registered state; there is no input-to-output path on them.

## Structure
- Shared package: opcode constants, jal encodings, state enum, and the NOP encoding constant. These are also used by the control unit.
- One sub-module is natural: next_pc_mux, purely combinational target selection and the misalignment flag. The FSM, PC, instruction register and counter stay in the top module.

## Test plan
- Reset with RESET_PC=32'h100 and imem_rvalid tied high -> imem_addr 0x100, 0x104, 0x108 on successive FETCH cycles; instr_valid pulses every 2nd cycle; retire_count=3 after three EXECs.
- JAL at pc 0x10 with imm=0x20 -> next imem_addr=0x30, pc_plus4=0x14 during EXEC.
- JALR with rs1_data=0x203, imm=0 -> target 0x202, bit1 set -> misaligned=1, halted=1, pc stays at the JALR address, retire_count not incremented.
- Branch with branch_taken=0 then 1 (imm=-8 at pc 0x40) -> next fetch 0x44, then 0x38.
- stopflag in EXEC -> halted=1, retire_count incremented; imem_req=0 forever; imem_rvalid pulses ignored until rst.
- rst asserted mid-FETCH with 3 wait cycles outstanding -> outputs return to reset values in the same cycle; the next fetch is from RESET_PC.
